lcd_id_detect: RTL

LCD_ID_DETECT -- requirements
Module: lcd_id_detect

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_id_lut.sv | 48 ++++
 rtl/lcd_id_detect.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for LCD panel strap detection.
// Holds FSM encoding, panel IDs and resolutions.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;

  localparam logic [10:0] RES_272  = 11'd272;
  localparam logic [10:0] RES_480  = 11'd480;
  localparam logic [10:0] RES_600  = 11'd600;
  localparam logic [10:0] RES_800  = 11'd800;
  localparam logic [10:0] RES_1024 = 11'd1024;
  localparam logic [10:0] RES_1280 = 11'd1280;

  localparam logic [15:0] ID_FALLBACK = ID_4384;
  localparam logic [10:0] H_FALLBACK  = RES_800;
  localparam logic [10:0] V_FALLBACK  = RES_480;

endpackage

// File: rtl/lcd_id_lut.sv
// Strap code to panel ID / resolution lookup.
// Unknown codes return the fallback panel with unknown set.
module lcd_id_lut
  import lcd_pkg::*;
(
  input  logic [2:0]  code,
  output logic [15:0] id,
  output logic [10:0] h,
  output logic [10:0] v,
  output logic        unknown
);

  always_comb begin
    id      = ID_FALLBACK;
    h       = H_FALLBACK;
    v       = V_FALLBACK;
    unknown = 1'b0;
    case (code)
      3'b000: begin
        id = ID_4342;
        h  = RES_480;
        v  = RES_272;
      end
      3'b001: begin
        id = ID_7084;
        h  = RES_800;
        v  = RES_480;
      end
      3'b010: begin
        id = ID_7016;
        h  = RES_1024;
        v  = RES_600;
      end
      3'b100: begin
        id = ID_4384;
        h  = RES_800;
        v  = RES_480;
      end
      3'b101: begin
        id = ID_1018;
        h  = RES_1280;
        v  = RES_800;
      end
      default: unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/lcd_id_detect.sv
// Samples LCD strap pins after a settle delay, debounces them
// over several samples and publishes the detected panel ID.
module lcd_id_detect
  import lcd_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int NUM_SAMPLES     = 8,
  parameter int SAMPLE_INTERVAL = 16,
  parameter int MAX_RETRY       = 4,
  parameter int M0_BIT          = 15,
  parameter int M1_BIT          = 10,
  parameter int M2_BIT          = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lcd_rgb,
  input  logic        redetect,
  output logic        strap_sampling,
  output logic [15:0] lcd_id,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        id_valid,
  output logic        id_err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int WW = $clog2(SAMPLE_INTERVAL + 1);
  localparam int IW = $clog2(NUM_SAMPLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_RELOAD = WW'(SAMPLE_INTERVAL - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_SAMPLES - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] settle_cnt;
  logic [WW-1:0] wait_cnt;
  logic [IW-1:0] idx_cnt;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    ref_code;
  logic          pend;
  logic          pend_fail;

  logic [2:0]    code;
  logic [15:0]   lut_id;
  logic [10:0]   lut_h;
  logic [10:0]   lut_v;
  logic          lut_unknown;
  logic          unused_rgb;

  assign code = {lcd_rgb[M2_BIT], lcd_rgb[M1_BIT], lcd_rgb[M0_BIT]};
  assign unused_rgb = ^lcd_rgb;

  lcd_id_lut u_lut (
    .code    (ref_code),
    .id      (lut_id),
    .h       (lut_h),
    .v       (lut_v),
    .unknown (lut_unknown)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = ST_SAMPLE;
      ST_SAMPLE: if (pend) state_next = ST_DONE;
      ST_DONE:   if (redetect) state_next = ST_SETTLE;
      default:   state_next = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_SETTLE;
      settle_cnt     <= '0;
      wait_cnt       <= '0;
      idx_cnt        <= '0;
      retry_cnt      <= '0;
      ref_code       <= '0;
      pend           <= 1'b0;
      pend_fail      <= 1'b0;
      strap_sampling <= 1'b1;
      lcd_id         <= '0;
      h_disp         <= '0;
      v_disp         <= '0;
      id_valid       <= 1'b0;
      id_err         <= 1'b0;
    end else begin
      state          <= state_next;
      strap_sampling <= (state_next != ST_DONE);
      unique case (state)
        ST_SETTLE: begin
          if (settle_cnt != SETTLE_LAST)
            settle_cnt <= settle_cnt + SW'(1);
          wait_cnt <= '0;
          idx_cnt  <= '0;
        end
        ST_SAMPLE: begin
          if (pend) begin
            // result commits one edge after the deciding sample
            pend     <= 1'b0;
            id_valid <= 1'b1;
            if (pend_fail) begin
              lcd_id <= ID_FALLBACK;
              h_disp <= H_FALLBACK;
              v_disp <= V_FALLBACK;
              id_err <= 1'b1;
            end else begin
              lcd_id <= lut_id;
              h_disp <= lut_h;
              v_disp <= lut_v;
              id_err <= lut_unknown;
            end
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WW'(1);
          end else begin
            wait_cnt <= WAIT_RELOAD;
            if (idx_cnt == '0) begin
              ref_code <= code;
              idx_cnt  <= IW'(1);
            end else if (code == ref_code) begin
              if (idx_cnt == IDX_LAST) begin
                pend      <= 1'b1;
                pend_fail <= 1'b0;
              end else begin
                idx_cnt <= idx_cnt + IW'(1);
              end
            end else begin
              retry_cnt <= retry_cnt + RW'(1);
              idx_cnt   <= '0;
              if (retry_cnt == RETRY_LAST) begin
                pend      <= 1'b1;
                pend_fail <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (redetect) begin
            id_valid   <= 1'b0;
            id_err     <= 1'b0;
            retry_cnt  <= '0;
            settle_cnt <= '0;
            wait_cnt   <= '0;
            idx_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
